// File: rtl/soc_system_sw_pkg.sv
// Shared constants for the switch/button event controller: the Avalon
// register map and the per-bit debounce state encoding.
package soc_system_sw_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_EDGESEL = 2'd3;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/sw_debounce_cell.sv
// One switch input: two-flop synchroniser, debounce FSM with a saturating
// stability counter, and registered one-cycle rise/fall pulses that line up
// with the cycle after the debounced level changes.
module sw_debounce_cell
  import soc_system_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_level;
  db_state_e        state;
  db_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;

  // Bring the asynchronous pin into the clk domain through two flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
    end else begin
      sync_meta  <= raw;
      sync_level <= sync_meta;
    end
  end

  // Hold FSM state, counter and debounced level; edge pulses are registered with the level change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= ~level & level_next;
      fall  <= level & ~level_next;
    end
  end

  // Accept a new level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    case (state)
      ST_STABLE: begin
        if (sync_level != level) begin
          state_next = ST_COUNTING;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      ST_COUNTING: begin
        if (sync_level == level) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          level_next = sync_level;
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/soc_system_sw_event_ctrl.sv
// Avalon-MM slave presenting debounced switch levels, per-bit edge capture
// with selectable polarity, and a maskable level interrupt to the HPS.
// reset_n is expected to be released synchronously to clk by the system
// reset controller; assertion takes effect asynchronously.
module soc_system_sw_event_ctrl
  import soc_system_sw_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgesel;
  logic [WIDTH-1:0] events;
  logic [WIDTH-1:0] cap_clear;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  // Register bits above WIDTH have no storage; fold them away explicitly
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sw_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (in_port[i]),
      .level  (debounced[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign wr_en     = chipselect & ~write_n;
  assign events    = (edgesel & fall) | (~edgesel & rise);
  assign cap_clear = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // Software-owned mask and edge-polarity registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgesel <= '0;
    end else if (wr_en) begin
      if (address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      if (address == ADDR_EDGESEL) edgesel <= writedata[WIDTH-1:0];
    end
  end

  // Latch events; a write-one-clear loses to an event arriving in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else begin
      edgecap <= (edgecap & ~cap_clear) | events;
    end
  end

  // Registered level interrupt from any enabled captured event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edgecap & irqmask);
    end
  end

  // Read mux is evaluated every cycle; unimplemented upper bits read as zero
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = debounced;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      ADDR_EDGESEL: rd_mux[WIDTH-1:0] = edgesel;
      default:      rd_mux = '0;
    endcase
  end

  // Register read data for a fixed one-cycle read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_soc_system_sw_event_ctrl.sv
// Scoreboard bench for soc_system_sw_event_ctrl. A behavioural model tracks
// how long each synchronised input has disagreed with its accepted level and
// pushes the expected read word every cycle; a monitor pops and compares it
// together with irq on the falling edge.
module tb_soc_system_sw_event_ctrl;
  import soc_system_sw_pkg::*;

  localparam int WIDTH = 4;
  localparam int N     = 8;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b0;
  logic [1:0]       address    = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = 32'd0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port    = '0;
  logic             irq;

  int vectors     = 0;
  int miscompares = 0;

  soc_system_sw_event_ctrl #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] m_pin_d1 = '0;
  logic [WIDTH-1:0] m_pin_d2 = '0;
  logic [WIDTH-1:0] m_level  = '0;
  logic [WIDTH-1:0] m_mask   = '0;
  logic [WIDTH-1:0] m_sel    = '0;
  logic [WIDTH-1:0] m_cap    = '0;
  logic [WIDTH-1:0] m_rose   = '0;
  logic [WIDTH-1:0] m_fell   = '0;
  logic             m_irq    = 1'b0;
  int               m_run[WIDTH];
  logic [31:0]      exp_q[$];

  logic [WIDTH-1:0] t_level;
  logic [WIDTH-1:0] t_evt;
  logic [WIDTH-1:0] t_clr;
  logic [31:0]      t_rd;
  logic             t_wr;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a level is accepted after N consecutive disagreeing samples of the delayed pin
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pin_d1 = '0; m_pin_d2 = '0; m_level = '0; m_mask = '0; m_sel = '0;
      m_cap = '0; m_rose = '0; m_fell = '0; m_irq = 1'b0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
      exp_q.delete();
    end else begin
      t_wr = chipselect && !write_n;
      t_rd = 32'd0;
      case (address)
        ADDR_DATA:    t_rd[WIDTH-1:0] = m_level;
        ADDR_IRQMASK: t_rd[WIDTH-1:0] = m_mask;
        ADDR_EDGECAP: t_rd[WIDTH-1:0] = m_cap;
        default:      t_rd[WIDTH-1:0] = m_sel;
      endcase
      exp_q.push_back(t_rd);
      t_evt = (m_rose & ~m_sel) | (m_fell & m_sel);
      t_clr = (t_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
      m_irq = |(m_cap & m_mask);
      m_cap = (m_cap & ~t_clr) | t_evt;
      if (t_wr && address == ADDR_IRQMASK) m_mask = writedata[WIDTH-1:0];
      if (t_wr && address == ADDR_EDGESEL) m_sel  = writedata[WIDTH-1:0];
      t_level = m_level;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_pin_d2[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin
            t_level[i] = m_pin_d2[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_rose   = t_level & ~m_level;
      m_fell   = ~t_level & m_level;
      m_level  = t_level;
      m_pin_d2 = m_pin_d1;
      m_pin_d1 = in_port;
    end
  end

  // Monitor: compare registered outputs away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      check_output("reset_readdata", readdata, 32'd0);
      check_output("reset_irq", {31'd0, irq}, 32'd0);
    end else begin
      if (exp_q.size() > 0) check_output("readdata", readdata, exp_q.pop_front());
      check_output("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic apply_stimulus(input logic [1:0] addr, input logic wr, input logic [31:0] data,
                                input logic [WIDTH-1:0] pins, input int cycles);
    address    = addr;
    chipselect = wr;
    write_n    = ~wr;
    writedata  = data;
    in_port    = pins;
    repeat (cycles) @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  logic [WIDTH-1:0] pins;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Bounce shorter than the debounce window is rejected
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0, 4'h1, 5);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0, 4'h0, 12);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h0, 2);

    // Accepted rising edge raises the capture bit and then irq
    apply_stimulus(ADDR_IRQMASK, 1'b1, 32'h1, 4'h0, 1);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0, 4'h1, 11);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h1, 3);

    // Release, then a W1C landing on the same edge as a new capture
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h0, 12);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h1, 10);
    apply_stimulus(ADDR_EDGECAP, 1'b1, 32'h1, 4'h1, 1);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h1, 3);
    apply_stimulus(ADDR_EDGECAP, 1'b1, 32'h1, 4'h1, 1);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h1, 3);

    // Falling-edge select on bit1
    apply_stimulus(ADDR_EDGESEL, 1'b1, 32'h2, 4'h1, 1);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h3, 12);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h1, 14);

    // Register readback, width truncation and read-only DATA
    apply_stimulus(ADDR_IRQMASK, 1'b1, 32'hF, 4'h1, 1);
    apply_stimulus(ADDR_IRQMASK, 1'b0, 32'd0, 4'h1, 2);
    apply_stimulus(ADDR_EDGESEL, 1'b1, 32'hFFFF_FFFF, 4'h1, 1);
    apply_stimulus(ADDR_EDGESEL, 1'b0, 32'd0, 4'h1, 2);
    apply_stimulus(ADDR_DATA, 1'b1, 32'hF, 4'h1, 1);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0, 4'h1, 2);
    apply_stimulus(ADDR_EDGESEL, 1'b1, 32'h0, 4'h1, 1);

    // Randomised traffic on pins and registers
    pins = 4'h1;
    for (int k = 0; k < 300; k++) begin
      logic wr;
      if ($urandom_range(0, 2) == 0) pins = pins ^ WIDTH'($urandom_range(1, 15));
      wr = ($urandom_range(0, 3) == 0);
      apply_stimulus(2'($urandom_range(0, 3)), wr, $urandom, pins,
                     wr ? 1 : int'($urandom_range(1, 14)));
    end

    // Reset in the middle of a count, with switches held through it
    apply_stimulus(ADDR_IRQMASK, 1'b1, 32'hF, 4'h5, 1);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0, 4'h5, 6);
    pulse_reset(3);
    for (int a = 0; a < 4; a++) apply_stimulus(2'(a), 1'b0, 32'd0, 4'h5, 1);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0, 4'h5, 10);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h5, 4);
    apply_stimulus(ADDR_IRQMASK, 1'b1, 32'h5, 4'h5, 1);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0, 4'h5, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
